systolic_output_deskew: RTL and testbench
=========================================

SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

Interface
REQ-001 SHALL have parameters: LANES, default 8, number of systolic columns; ACC_W, default 16, signed accumulator width per lane; ADDR_W, default 10, BRAM address width.
REQ-002 SHALL have ports:
 clk_i  in  1  sole clock, rising edge
 rst_i  in  1  synchronous, active-high reset
 start_i  in  1  job start pulse
 base_addr_i  in  ADDR_W  first BRAM write address
 num_rows_i  in  ADDR_W  rows to collect
 shift_i  in  4  arithmetic right-shift for requantisation
 en_i  in  1  pipeline advance enable
 valid_i  in  1  lane 0 of a new skewed row is present
 skew_i  in  LANES*ACC_W  column outputs, lane k at bits [k*ACC_W +: ACC_W]
 bram_we_o  out  1  write strobe
 bram_addr_o  out  ADDR_W  write address
 bram_din_o  out  LANES*8  packed int8 row, lane k at bits [k*8 +: 8]
 busy_o  out  1  job active
 done_o  out  1  one-cycle completion pulse
 sat_o  out  1  sticky saturation flag for current job

Function
REQ-003 Skew model: row r lane k SHALL be presented on skew_i exactly k cycles after the cycle in which valid_i marks row r (lane 0).
REQ-004 Lane k SHALL pass through LANES-1-k delay registers; lane LANES-1 has zero delay; an accept tag SHALL pass through LANES-1 registers.
REQ-005 Requant per lane: arithmetic shift right by shift_i, then saturate to signed [-128,127]; any clipped lane in a written row SHALL set sat_o.
REQ-006 Output stage SHALL be one register: a row whose valid_i cycle is c SHALL appear with bram_we_o=1 in cycle c+LANES (en_i held high).
REQ-007 FSM states IDLE, RUN, DONE: IDLE->RUN on start_i (latch base_addr_i, num_rows_i, shift_i; clear row counters and sat_o); RUN->DONE in the cycle after the num_rows-th write; DONE->IDLE unconditionally after one cycle.
REQ-008 done_o SHALL be 1 only in DONE; busy_o SHALL be 1 in RUN and DONE.
REQ-009 valid_i SHALL be accepted only in RUN with en_i=1 and accepted count < num_rows; otherwise ignored and never written.
REQ-010 start_i outside IDLE SHALL be ignored.
REQ-011 num_rows_i=0: RUN SHALL go to DONE next cycle with no write.
REQ-012 bram_addr_o SHALL start at base_addr and increment by 1 after each write, wrapping modulo 2^ADDR_W.
REQ-013 en_i=0 SHALL freeze all delay registers, the accept tags, counters and output stage, and force bram_we_o=0; resumption SHALL lose or duplicate no row.
REQ-014 Back-to-back valid_i on consecutive cycles SHALL produce writes on consecutive cycles.

Reset
REQ-015 rst_i=1 at a clock edge SHALL set state IDLE and bram_we_o, bram_addr_o, bram_din_o, busy_o, done_o, sat_o, all delay registers and tags to 0.
REQ-016 rst_i mid-job SHALL discard in-flight rows; no write SHALL occur in the cycle following reset.

Structure
REQ-017 LANES, ACC_W, ADDR_W defaults and the FSM state encoding SHALL reside in the shared def.v package.
REQ-018 Requantisation SHALL be a sub-module requant_sat8 (combinational: ACC_W in, shift, int8 out, clip flag), instantiated LANES times.

Verification
REQ-019 Bench SHALL cover:
 - Base 0x010, 4 rows, shift 0, lane k of row r = r*8+k, correctly skewed -> writes 0x010..0x013 in cycles c+8.., lane k byte = r*8+k, done_o one cycle after last write.
 - Shift 4, lane values 0x7FFF and -0x8000 -> bytes 0x7F and 0x80, sat_o=1; values 0x0100 -> 0x10, sat_o stays 0 in a clean job.
 - en_i low 3 cycles mid-row -> same 4 words as no-stall case, no write while en_i=0.
 - Base 0x3FE, 4 rows -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
 - num_rows 2 with 5 valid_i pulses; start_i during RUN -> exactly 2 writes, second start ignored; num_rows 0 -> done_o 2 cycles after start, no write.
 - rst_i asserted with 3 rows in flight -> all outputs 0 next cycle, no subsequent writes, new job runs clean.

Source files
------------

// File: rtl/systolic_output_deskew_pkg.sv
// Shared defaults and FSM encoding for the systolic output deskew block.
package systolic_output_deskew_pkg;

    localparam int unsigned LANES_DEF  = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/requant_sat8.sv
// Requantises one signed accumulator lane to int8: arithmetic shift, then clamp.
module requant_sat8
    import systolic_output_deskew_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       shift_i,
    output logic [7:0]       q_o,
    output logic             clip_o
);

    localparam logic signed [ACC_W-1:0] QMax = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] QMin = ACC_W'(-128);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = $signed(acc_i) >>> shift_i;
        q_o     = shifted[7:0];
        clip_o  = 1'b0;
        if (shifted > QMax) begin
            q_o    = 8'h7f;
            clip_o = 1'b1;
        end else if (shifted < QMin) begin
            q_o    = 8'h80;
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns skewed systolic column outputs, requantises each row to int8 and writes it to BRAM.
module systolic_output_deskew
    import systolic_output_deskew_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      base_addr_i,
    input  logic [ADDR_W-1:0]      num_rows_i,
    input  logic [3:0]             shift_i,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  logic [LANES*ACC_W-1:0] skew_i,
    output logic                   bram_we_o,
    output logic [ADDR_W-1:0]      bram_addr_o,
    output logic [LANES*8-1:0]     bram_din_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sat_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   num_rows_q, num_rows_d;
    logic [ADDR_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          shift_q, shift_d;
    logic                sat_q, sat_d;
    logic                we_q, we_d;
    logic [LANES*8-1:0]  din_q, din_d;
    logic [LANES-2:0]    tag_q;

    logic [ACC_W-1:0]    aligned [LANES];
    logic [7:0]          lane_q8 [LANES];
    logic [LANES-1:0]    lane_clip;
    logic [LANES*8-1:0]  row_din;
    logic                accept;
    logic                tag_out;
    logic                write;

    // Lane k arrives k cycles after lane 0, so it waits LANES-1-k enabled cycles to line up.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int Depth = int'(LANES) - 1 - k;
        if (Depth == 0) begin : g_direct
            assign aligned[k] = skew_i[k*ACC_W +: ACC_W];
        end else begin : g_delay
            logic [ACC_W-1:0] dly_q [Depth];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < Depth; i++) dly_q[i] <= '0;
                end else if (en_i) begin
                    dly_q[0] <= skew_i[k*ACC_W +: ACC_W];
                    for (int i = 1; i < Depth; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign aligned[k] = dly_q[Depth-1];
        end

        requant_sat8 #(
            .ACC_W (ACC_W)
        ) u_requant (
            .acc_i   (aligned[k]),
            .shift_i (shift_q),
            .q_o     (lane_q8[k]),
            .clip_o  (lane_clip[k])
        );
    end

    always_comb begin
        row_din = '0;
        for (int k = 0; k < int'(LANES); k++) row_din[k*8 +: 8] = lane_q8[k];
    end

    assign accept  = (state_q == StRun) && en_i && valid_i && (acc_cnt_q < num_rows_q);
    assign tag_out = tag_q[LANES-2];
    // A held output row is only committed on an enabled cycle, so a stall cannot repeat it.
    assign write   = we_q && en_i;

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        sat_d      = sat_q;
        we_d       = we_q;
        din_d      = din_q;

        if (en_i) begin
            we_d = tag_out;
            if (tag_out) begin
                din_d = row_din;
                sat_d = sat_q | (|lane_clip);
            end
        end
        if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
        if (write) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            addr_d   = addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRun;
                    addr_d     = base_addr_i;
                    num_rows_d = num_rows_i;
                    shift_d    = shift_i;
                    acc_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    sat_d      = 1'b0;
                end
            end
            StRun: begin
                if (wr_cnt_d == num_rows_q) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            num_rows_q <= '0;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            sat_q      <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            sat_q      <= sat_d;
            we_q       <= we_d;
            din_q      <= din_d;
            if (en_i) tag_q <= (tag_q << 1) | (LANES-1)'(accept);
        end
    end

    assign bram_we_o   = write;
    assign bram_addr_o = addr_q;
    assign bram_din_o  = din_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Randomised and directed bench for systolic_output_deskew against a row-level scoreboard model.
module tb_systolic_output_deskew;

    localparam int L  = 8;
    localparam int AW = 16;
    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            rst_i, start_i, en_i, valid_i;
    logic [DW-1:0]   base_addr_i, num_rows_i;
    logic [3:0]      shift_i;
    logic [L*AW-1:0] skew_i;
    logic            bram_we_o, busy_o, done_o, sat_o;
    logic [DW-1:0]   bram_addr_o;
    logic [L*8-1:0]  bram_din_o;

    always #5 clk = ~clk;

    systolic_output_deskew #(
        .LANES  (L),
        .ACC_W  (AW),
        .ADDR_W (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_rows_i  (num_rows_i),
        .shift_i     (shift_i),
        .en_i        (en_i),
        .valid_i     (valid_i),
        .skew_i      (skew_i),
        .bram_we_o   (bram_we_o),
        .bram_addr_o (bram_addr_o),
        .bram_din_o  (bram_din_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sat_o       (sat_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: rows are scheduled in "enabled-cycle time"; a row whose valid_i is on enabled
    // cycle e is written on enabled cycle e+L, at base + (rows written so far).
    typedef struct {
        int             tick;
        logic [L*8-1:0] din;
        bit             clip;
    } pend_t;

    pend_t          pq[$];
    int             en_idx = 0;
    bit             has_row [4096];
    logic [AW-1:0]  row_mem [4096][L];
    logic [AW-1:0]  nxt_row [L];
    int             ph = 0;
    logic [DW-1:0]  m_base = '0;
    int             m_nrows = 0, m_acc = 0, m_wr = 0, m_shift = 0;
    bit             m_sat = 0, prev_rs = 0;
    logic [DW-1:0]  j_base, j_nrows;
    logic [3:0]     j_shift;

    bit             chk_en = 0;
    bit             exp_we = 0, exp_busy = 0, exp_done = 0, exp_satchk = 0, exp_sat = 0;
    bit             post_rst = 0;
    logic [DW-1:0]  exp_addr = '0;
    logic [L*8-1:0] exp_din = '0;

    logic [DW-1:0]  wl_addr[$];
    logic [L*8-1:0] wl_din[$];
    int             wl_cyc[$];
    bit             wl_en[$];
    int             done_cyc = -1;
    bit             done_sat = 0;

    function automatic void model_row(output logic [L*8-1:0] d, output bit c);
        int x;
        c = 0;
        d = '0;
        for (int k = 0; k < L; k++) begin
            x = {{(32-AW){nxt_row[k][AW-1]}}, nxt_row[k]};
            x = x >>> m_shift;
            if (x > 127) begin
                x = 127;
                c = 1;
            end else if (x < -128) begin
                x = -128;
                c = 1;
            end
            d[k*8 +: 8] = 8'(x);
        end
    endfunction

    task automatic tick(input bit st, input bit vld, input bit en, input bit rs);
        logic [L*8-1:0] d;
        bit             c;
        int             e;
        rst_i       = rs;
        start_i     = st;
        valid_i     = vld;
        en_i        = en;
        base_addr_i = st ? j_base : DW'($urandom);
        num_rows_i  = st ? j_nrows : DW'($urandom);
        shift_i     = st ? j_shift : 4'($urandom);
        if (en) begin
            has_row[en_idx] = vld;
            if (vld) for (int k = 0; k < L; k++) row_mem[en_idx][k] = nxt_row[k];
            for (int k = 0; k < L; k++) begin
                e = en_idx - k;
                skew_i[k*AW +: AW] = (e >= 0 && has_row[e]) ? row_mem[e][k] : AW'($urandom);
            end
        end else begin
            for (int k = 0; k < L; k++) skew_i[k*AW +: AW] = AW'($urandom);
        end

        exp_busy   = (ph != 0);
        exp_done   = (ph == 2);
        exp_satchk = (ph == 2);
        exp_sat    = m_sat;
        exp_we     = en && (pq.size() > 0) && (pq[0].tick == en_idx);
        exp_addr   = m_base + DW'(m_wr);
        exp_din    = exp_we ? pq[0].din : '0;
        post_rst   = prev_rs;
        prev_rs    = rs;

        if (rs) begin
            ph     = 0;
            pq.delete();
            m_sat  = 0;
            m_wr   = 0;
            m_acc  = 0;
            m_base = '0;
        end else begin
            if (exp_we) begin
                m_sat = m_sat | pq[0].clip;
                void'(pq.pop_front());
                m_wr++;
            end
            if (ph == 1 && en && vld && m_acc < m_nrows) begin
                model_row(d, c);
                pq.push_back('{tick: en_idx + L, din: d, clip: c});
                m_acc++;
            end
            case (ph)
                0: if (st) begin
                    ph      = 1;
                    m_base  = j_base;
                    m_nrows = int'(j_nrows);
                    m_shift = int'(j_shift);
                    m_acc   = 0;
                    m_wr    = 0;
                    m_sat   = 0;
                end
                1: if (m_wr == m_nrows) ph = 2;
                default: ph = 0;
            endcase
        end
        if (en) en_idx++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("we", bram_we_o, exp_we);
            check("busy", busy_o, exp_busy);
            check("done", done_o, exp_done);
            if (exp_we) begin
                check("addr", bram_addr_o, exp_addr);
                check("din", bram_din_o, exp_din);
            end
            if (exp_satchk) check("sat", sat_o, exp_sat);
            if (post_rst) begin
                check("rst_addr", bram_addr_o, 0);
                check("rst_din", bram_din_o, 0);
                check("rst_sat", sat_o, 0);
            end
        end
        if (bram_we_o === 1'b1) begin
            wl_addr.push_back(bram_addr_o);
            wl_din.push_back(bram_din_o);
            wl_cyc.push_back(cyc);
            wl_en.push_back(en_i);
        end
        if (done_o === 1'b1) begin
            done_cyc = cyc;
            done_sat = sat_o;
        end
    end

    task automatic clear_log();
        wl_addr.delete();
        wl_din.delete();
        wl_cyc.delete();
        wl_en.delete();
        done_cyc = -1;
    endtask

    task automatic start_job(input logic [DW-1:0] b, input logic [DW-1:0] n, input logic [3:0] s);
        j_base  = b;
        j_nrows = n;
        j_shift = s;
        tick(1, 0, 1, 0);
    endtask

    task automatic ramp_row(input int r);
        for (int k = 0; k < L; k++) nxt_row[k] = AW'(r * 8 + k);
    endtask

    function automatic logic [63:0] ramp_word(input int r);
        logic [63:0] w;
        for (int k = 0; k < L; k++) w[k*8 +: 8] = 8'(r * 8 + k);
        return w;
    endfunction

    int vc[4];
    int sc;
    int nstall;

    initial begin
        j_base  = '0;
        j_nrows = '0;
        j_shift = '0;
        for (int k = 0; k < L; k++) nxt_row[k] = '0;
        repeat (3) tick(0, 0, 1, 1);
        chk_en = 1;

        // Ramp job, no stalls: writes at valid cycle + 8, done right after the last one.
        start_job(10'h010, 10'd4, 4'd0);
        clear_log();
        for (int r = 0; r < 4; r++) begin
            ramp_row(r);
            vc[r] = cyc;
            tick(0, 1, 1, 0);
        end
        repeat (14) tick(0, 0, 1, 0);
        check("t1_nwr", wl_addr.size(), 4);
        if (wl_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_addr", wl_addr[i], 64'(10'h010 + i));
                check("t1_din", wl_din[i], ramp_word(i));
                check("t1_cyc", wl_cyc[i], vc[i] + 8);
            end
            check("t1_done", done_cyc, wl_cyc[3] + 1);
        end

        // Saturation: +max / -min clip, then a clean job leaves sat_o low.
        start_job(10'h020, 10'd1, 4'd4);
        clear_log();
        for (int k = 0; k < L; k++) nxt_row[k] = (k % 2 == 0) ? 16'h7fff : 16'h8000;
        tick(0, 1, 1, 0);
        repeat (12) tick(0, 0, 1, 0);
        check("t2_din_clip", wl_din.size() > 0 ? wl_din[0] : 64'hx, 64'h807f807f807f807f);
        check("t2_sat_set", done_sat, 1);
        start_job(10'h030, 10'd1, 4'd4);
        clear_log();
        for (int k = 0; k < L; k++) nxt_row[k] = 16'h0100;
        tick(0, 1, 1, 0);
        repeat (12) tick(0, 0, 1, 0);
        check("t2_din_clean", wl_din.size() > 0 ? wl_din[0] : 64'hx, 64'h1010101010101010);
        check("t2_sat_clear", done_sat, 0);

        // Stalls mid-row and mid-output must give the same four words.
        start_job(10'h010, 10'd4, 4'd0);
        clear_log();
        for (int r = 0; r < 4; r++) begin
            ramp_row(r);
            tick(0, 1, 1, 0);
            if (r == 1) repeat (3) tick(0, 1, 0, 0);
        end
        for (int i = 0; i < 20; i++) tick(0, 0, !(i >= 5 && i < 8), 0);
        check("t3_nwr", wl_addr.size(), 4);
        nstall = 0;
        foreach (wl_en[i]) if (!wl_en[i]) nstall++;
        check("t3_we_in_stall", nstall, 0);
        if (wl_addr.size() == 4)
            for (int i = 0; i < 4; i++) check("t3_din", wl_din[i], ramp_word(i));

        // Address wrap.
        start_job(10'h3fe, 10'd4, 4'd2);
        clear_log();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < L; k++) nxt_row[k] = AW'($urandom);
            tick(0, 1, 1, 0);
        end
        repeat (14) tick(0, 0, 1, 0);
        check("t4_nwr", wl_addr.size(), 4);
        if (wl_addr.size() == 4) begin
            check("t4_a0", wl_addr[0], 10'h3fe);
            check("t4_a1", wl_addr[1], 10'h3ff);
            check("t4_a2", wl_addr[2], 10'h000);
            check("t4_a3", wl_addr[3], 10'h001);
        end

        // Excess valids and a stray start during RUN; then an empty job.
        start_job(10'h100, 10'd2, 4'd0);
        clear_log();
        for (int r = 0; r < 5; r++) begin
            ramp_row(r);
            tick(r == 2, 1, 1, 0);
        end
        repeat (14) tick(0, 0, 1, 0);
        check("t5_nwr", wl_addr.size(), 2);
        if (wl_addr.size() == 2) check("t5_done", done_cyc, wl_cyc[1] + 1);
        clear_log();
        sc = cyc;
        start_job(10'h200, 10'd0, 4'd0);
        repeat (6) tick(0, 1, 1, 0);
        check("t5_zero_done", done_cyc, sc + 2);
        check("t5_zero_nwr", wl_addr.size(), 0);

        // Reset with rows in flight.
        start_job(10'h155, 10'd4, 4'd0);
        for (int r = 0; r < 3; r++) begin
            ramp_row(r);
            tick(0, 1, 1, 0);
        end
        repeat (2) tick(0, 0, 1, 0);
        clear_log();
        tick(0, 0, 1, 1);
        check("t6_we", bram_we_o, 0);
        check("t6_addr", bram_addr_o, 0);
        check("t6_din", bram_din_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_sat", sat_o, 0);
        repeat (15) tick(0, 0, 1, 0);
        check("t6_nwr", wl_addr.size(), 0);
        start_job(10'h040, 10'd2, 4'd0);
        clear_log();
        for (int r = 0; r < 2; r++) begin
            ramp_row(r + 4);
            tick(0, 1, 1, 0);
        end
        repeat (12) tick(0, 0, 1, 0);
        check("t6_new_nwr", wl_addr.size(), 2);
        if (wl_addr.size() == 2) check("t6_new_din", wl_din[1], ramp_word(5));

        // Random traffic: stalls, random data/shift, stray starts and rare resets.
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < 40; i++) begin
                j_base  = DW'($urandom);
                j_nrows = DW'($urandom_range(0, 6));
                j_shift = 4'($urandom_range(0, 15));
                for (int k = 0; k < L; k++) nxt_row[k] = AW'($urandom);
                tick($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
            end
            for (int i = 0; i < 10; i++) begin
                for (int k = 0; k < L; k++) nxt_row[k] = AW'($urandom);
                tick(0, 1, 1, 0);
            end
            repeat (14) tick(0, 0, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
